// File: rtl/stats_display_pkg.sv
// Shared types and constants for the statistics display: FSM states,
// active-low 7-segment patterns and the double-dabble adjust step.
package stats_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; codes above 9
// produce a dark digit.
module bcd_to_seg7
    import stats_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stats_display.sv
// Shows one of four 11-bit statistics counters on a 4-digit multiplexed
// 7-segment display, converting to BCD with a sequential double-dabble engine.
module stats_display
    import stats_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] r_cnt,
    input  logic [CW-1:0] j_cnt,
    input  logic [CW-1:0] clk_cnt,
    input  logic [1:0]    sel,
    output logic [3:0]    an,
    output logic [6:0]    seg,
    output logic          dp,
    output logic          busy
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    // Scan timing
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_digit_tick;
    logic             w_frame_tick;

    // Conversion engine
    state_t           r_state;
    state_t           w_state_next;
    logic             r_kick;
    logic             r_busy;
    logic [1:0]       r_pend_sel;
    logic [1:0]       r_shown_sel;
    logic [CW-1:0]    r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] r_disp_bcd;
    logic [3:0]       r_iter;
    logic             w_start;
    logic [CW-1:0]    w_sel_cnt;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W+CW-1:0] w_cat;

    // Rendering
    logic [6:0]       w_dig_seg [BCD_DIGITS];
    logic [BCD_DIGITS-1:0] w_blank;
    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_next;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    assign w_digit_tick = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_frame_tick = w_digit_tick && (r_idx == 2'd3);
    assign w_idx_next   = r_idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (w_digit_tick) begin
            r_div <= '0;
            r_idx <= w_idx_next;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        w_sel_cnt = i_cnt;
        case (sel)
            2'd0:    w_sel_cnt = i_cnt;
            2'd1:    w_sel_cnt = r_cnt;
            2'd2:    w_sel_cnt = j_cnt;
            default: w_sel_cnt = clk_cnt;
        endcase
    end

    // Frame ticks seen outside IDLE are simply lost; nothing is queued.
    assign w_start = (r_state == IDLE) && (r_kick || w_frame_tick);
    assign w_adj   = dabble_adjust(r_bcd);
    assign w_cat   = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = SHIFT;
            SHIFT:   if (r_iter == 4'(CW - 1)) w_state_next = LOAD;
            LOAD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kick      <= 1'b1;
            r_busy      <= 1'b0;
            r_pend_sel  <= 2'd0;
            r_shown_sel <= 2'd0;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_disp_bcd  <= '0;
            r_iter      <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_pend_sel <= sel;
                        r_shift    <= w_sel_cnt;
                        r_bcd      <= '0;
                        r_kick     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_iter     <= 4'd0;
                    end
                end
                SHIFT: begin
                    r_bcd   <= w_cat[BCD_W+CW-1:CW];
                    r_shift <= w_cat[CW-1:0];
                    r_iter  <= r_iter + 4'd1;
                end
                LOAD: begin
                    r_disp_bcd  <= r_bcd;
                    r_shown_sel <= r_pend_sel;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
        bcd_to_seg7 u_dec (
            .i_nibble (r_disp_bcd[4*gi +: 4]),
            .o_seg    (w_dig_seg[gi])
        );
        if (gi == 0) begin : g_units
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = ~(|r_disp_bcd[BCD_W-1:4*gi]);
        end
    end

    // Render for the index being entered so outputs track it one cycle after the tick.
    always_comb begin
        w_dp_next  = (w_idx_next != r_shown_sel);
        w_seg_next = w_blank[w_idx_next] ? SEG_BLANK : w_dig_seg[w_idx_next];
        w_an_next  = 4'b1111;
        if (!w_blank[w_idx_next] || !w_dp_next) begin
            w_an_next[w_idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_digit_tick) begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign busy = r_busy;

endmodule

// File: tb/tb_stats_display.sv
// Directed checks of stats_display with SCAN_DIV=4: reset, conversion timing,
// digit rendering, input sampling and reset during a conversion.
module tb_stats_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] i_cnt = '0;
    logic [10:0] r_cnt = '0;
    logic [10:0] j_cnt = '0;
    logic [10:0] clk_cnt = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc;

    localparam logic [11:0] OUT_RST = {4'b1111, 7'h7F, 1'b1};

    always #5 clk = ~clk;

    // Edges since reset release; digit ticks land on edges 4,8,12,...
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    stats_display #(.SCAN_DIV(4), .CW(11)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_cnt   (i_cnt),
        .r_cnt   (r_cnt),
        .j_cnt   (j_cnt),
        .clk_cnt (clk_cnt),
        .sel     (sel),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .busy    (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [1:0] s, input logic [10:0] ic, input logic [10:0] rc,
                            input logic [10:0] jc, input logic [10:0] cc);
        @(negedge clk);
        reset   = 1'b1;
        sel     = s;
        i_cnt   = ic;
        r_cnt   = rc;
        j_cnt   = jc;
        clk_cnt = cc;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int c, output bit ok);
        int guard;
        guard = 0;
        while (cyc != c && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        ok = (cyc == c);
    endtask

    // Wait for the middle of the slot where digit n is being driven.
    task automatic sample_digit(input int n, input int min_c, output logic [11:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (cyc >= min_c && (cyc % 4) == 2 && ((cyc / 4) % 4) == n) begin
                ok = 1'b1;
                break;
            end
        end
        v = {an, seg, dp};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sel   = 2'd0;
        i_cnt = 11'd1234;
        repeat (3) @(negedge clk);
        total++;
        if ({an, seg, dp} !== OUT_RST) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", {an, seg, dp}, OUT_RST);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        reset = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            if (e == 2) begin
                total++;
                if ({an, seg, dp} !== OUT_RST) begin
                    bad++;
                    $display("FAIL pre_tick_outputs: got %h want %h", {an, seg, dp}, OUT_RST);
                end
            end
            total++;
            if (busy !== (e <= 12)) begin
                bad++;
                $display("FAIL busy_window cyc%0d: got %b want %b", e, busy, (e <= 12));
            end
        end
        $display("test_reset done at cyc %0d", cyc);
    endtask

    task automatic test_display(input string name, input logic [1:0] s,
                                input logic [10:0] ic, input logic [10:0] rc,
                                input logic [10:0] jc, input logic [10:0] cc,
                                input logic [11:0] e0, input logic [11:0] e1,
                                input logic [11:0] e2, input logic [11:0] e3);
        logic [11:0] exp_v [4];
        logic [11:0] v;
        bit ok;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        do_reset(s, ic, rc, jc, cc);
        for (int n = 0; n < 4; n++) begin
            sample_digit(n, 16, v, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s digit%0d: slot not reached, want %h", name, n, exp_v[n]);
            end else if (v !== exp_v[n]) begin
                bad++;
                $display("FAIL %s digit%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         name, n, v[11:8], v[7:1], v[0], exp_v[n][11:8], exp_v[n][7:1], exp_v[n][0]);
            end else begin
                $display("%s digit%0d an=%b seg=%h dp=%b", name, n, v[11:8], v[7:1], v[0]);
            end
        end
    endtask

    task automatic test_sampling;
        logic [11:0] v;
        bit ok;
        do_reset(2'd0, 11'd5, 11'd3, 11'd42, 11'd4);
        wait_cyc(4, ok);
        sel   = 2'd2;
        i_cnt = 11'd9;
        wait_cyc(12, ok);
        total++;
        if (!ok || busy !== 1'b1) begin
            bad++;
            $display("FAIL sample_busy_load: got %b want 1", busy);
        end
        wait_cyc(13, ok);
        total++;
        if (!ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL sample_busy_done: got %b want 0", busy);
        end
        sample_digit(0, 16, v, ok);
        total++;
        if (!ok || v !== {4'b1110, 7'h12, 1'b0}) begin
            bad++;
            $display("FAIL sample_first_d0: got %h want %h", v, {4'b1110, 7'h12, 1'b0});
        end else $display("sample first d0 an=%b seg=%h dp=%b", v[11:8], v[7:1], v[0]);
        sample_digit(0, 32, v, ok);
        total++;
        if (!ok || v !== {4'b1110, 7'h24, 1'b1}) begin
            bad++;
            $display("FAIL sample_next_d0: got %h want %h", v, {4'b1110, 7'h24, 1'b1});
        end else $display("sample next d0 an=%b seg=%h dp=%b", v[11:8], v[7:1], v[0]);
        sample_digit(1, 36, v, ok);
        total++;
        if (!ok || v !== {4'b1101, 7'h19, 1'b1}) begin
            bad++;
            $display("FAIL sample_next_d1: got %h want %h", v, {4'b1101, 7'h19, 1'b1});
        end else $display("sample next d1 an=%b seg=%h dp=%b", v[11:8], v[7:1], v[0]);
        sample_digit(2, 40, v, ok);
        total++;
        if (!ok || v !== {4'b1011, 7'h7F, 1'b0}) begin
            bad++;
            $display("FAIL sample_next_d2: got %h want %h", v, {4'b1011, 7'h7F, 1'b0});
        end else $display("sample next d2 an=%b seg=%h dp=%b", v[11:8], v[7:1], v[0]);
    endtask

    // Continues from test_sampling: conversion started at edge 48, iteration 6 at cycle 54.
    task automatic test_reset_mid;
        logic [11:0] exp_v [4];
        logic [11:0] v;
        bit ok;
        wait_cyc(54, ok);
        total++;
        if (!ok || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        total++;
        if ({an, seg, dp} !== {4'b1101, 7'h19, 1'b1}) begin
            bad++;
            $display("FAIL mid_pre_reset: got %h want %h", {an, seg, dp}, {4'b1101, 7'h19, 1'b1});
        end
        reset = 1'b1;
        #1;
        total++;
        if ({an, seg, dp} !== OUT_RST || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h busy=%b want %h busy=0", {an, seg, dp}, busy, OUT_RST);
        end
        sel     = 2'd3;
        clk_cnt = 11'd999;
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            total++;
            if (busy !== (e <= 12)) begin
                bad++;
                $display("FAIL mid_busy_window cyc%0d: got %b want %b", e, busy, (e <= 12));
            end
        end
        exp_v[0] = {4'b1110, 7'h10, 1'b1};
        exp_v[1] = {4'b1101, 7'h10, 1'b1};
        exp_v[2] = {4'b1011, 7'h10, 1'b1};
        exp_v[3] = {4'b0111, 7'h7F, 1'b0};
        for (int n = 0; n < 4; n++) begin
            sample_digit(n, 16, v, ok);
            total++;
            if (!ok || v !== exp_v[n]) begin
                bad++;
                $display("FAIL mid_restart digit%0d: got %h want %h", n, v, exp_v[n]);
            end else $display("mid_restart digit%0d an=%b seg=%h dp=%b", n, v[11:8], v[7:1], v[0]);
        end
    endtask

    initial begin
        test_reset;
        test_display("i1234", 2'd0, 11'd1234, 11'd77, 11'd88, 11'd99,
                     {4'b1110, 7'h19, 1'b0}, {4'b1101, 7'h30, 1'b1},
                     {4'b1011, 7'h24, 1'b1}, {4'b0111, 7'h79, 1'b1});
        test_display("clk2047", 2'd3, 11'd11, 11'd22, 11'd33, 11'd2047,
                     {4'b1110, 7'h78, 1'b1}, {4'b1101, 7'h19, 1'b1},
                     {4'b1011, 7'h40, 1'b1}, {4'b0111, 7'h24, 1'b0});
        test_display("r7", 2'd1, 11'd500, 11'd7, 11'd600, 11'd700,
                     {4'b1110, 7'h78, 1'b1}, {4'b1101, 7'h7F, 1'b0},
                     {4'b1111, 7'h7F, 1'b1}, {4'b1111, 7'h7F, 1'b1});
        test_display("clk0", 2'd3, 11'd1, 11'd2, 11'd3, 11'd0,
                     {4'b1110, 7'h40, 1'b1}, {4'b1111, 7'h7F, 1'b1},
                     {4'b1111, 7'h7F, 1'b1}, {4'b0111, 7'h7F, 1'b0});
        test_display("j1000", 2'd2, 11'd9, 11'd8, 11'd1000, 11'd6,
                     {4'b1110, 7'h40, 1'b1}, {4'b1101, 7'h40, 1'b1},
                     {4'b1011, 7'h40, 1'b0}, {4'b0111, 7'h79, 1'b1});
        test_sampling;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
